// File: rtl/rvfi_check_sequencer_if.sv
// rtl/rvfi_check_sequencer_if.sv - retirement valid in, check strobe and sequencing status out
interface rvfi_check_sequencer_if #(
  parameter int NRET  = 1,
  parameter int CNT_W = 16
);
  logic [NRET-1:0]  rvfi_valid;
  logic [NRET-1:0]  check;
  logic             core_reset;
  logic             armed;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] retire_count;
  logic [CNT_W-1:0] cycle_count;

  // The sequencer side: consumes retirements, produces strobes and status.
  modport master (
    input  rvfi_valid,
    output check, core_reset, armed, done, timeout, retire_count, cycle_count
  );

  // The harness side: supplies retirements, observes strobes and status.
  modport slave (
    output rvfi_valid,
    input  check, core_reset, armed, done, timeout, retire_count, cycle_count
  );
endinterface

// File: rtl/rvfi_check_sequencer.sv
// rtl/rvfi_check_sequencer.sv - core reset window and single check point on the SKIP-th retirement
module rvfi_check_sequencer #(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int SKIP         = 0,
  parameter int CHECK_DEPTH  = 20,
  parameter int CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  rvfi_check_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(CHECK_DEPTH - 1);
  // One extra bit so SKIP - retire_count and retire_count + n never alias.
  localparam logic [CNT_W:0]   SKIP_X     = (CNT_W + 1)'(SKIP);
  localparam logic [CNT_W:0]   ONE_X      = (CNT_W + 1)'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] retire_nxt;
  logic [CNT_W:0]   n_ret;
  logic [CNT_W:0]   k_idx;
  logic [CNT_W:0]   seen;
  logic [CNT_W:0]   retire_sum;
  logic [NRET-1:0]  pick;
  logic             hit;
  logic             fire;

  // Count this cycle's retirements and locate the k-th set bit from the LSB (oldest first).
  always_comb begin
    seen  = '0;
    pick  = '0;
    k_idx = SKIP_X - {1'b0, retire_q};
    for (int i = 0; i < NRET; i++) begin
      if (bus.rvfi_valid[i]) begin
        if (seen == k_idx) pick[i] = 1'b1;
        seen = seen + ONE_X;
      end
    end
    n_ret      = seen;
    hit        = ({1'b0, retire_q} <= SKIP_X) && (k_idx < n_ret);
    retire_sum = {1'b0, retire_q} + n_ret;
    retire_nxt = retire_sum[CNT_W] ? CNT_MAX : retire_sum[CNT_W-1:0];
  end

  // Next state: leave HOLD after the reset window, fire once in RUN or give up at the depth limit.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      HOLD: begin
        if (cycle_q == HOLD_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (hit) begin
          fire      = 1'b1;
          state_nxt = DONE;
        end else if (cycle_q == DEPTH_LAST) begin
          state_nxt = TIMEOUT;
        end
      end
      DONE:    state_nxt = DONE;
      TIMEOUT: state_nxt = TIMEOUT;
      default: state_nxt = HOLD;
    endcase
  end

  // State and saturating counters; retirements are only counted once the core is out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= HOLD;
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      state <= state_nxt;
      if (cycle_q != CNT_MAX) cycle_q <= cycle_q + CNT_ONE;
      if (state != HOLD) retire_q <= retire_nxt;
    end
  end

  // While reset is asserted the outputs look like HOLD regardless of the stored state.
  assign bus.core_reset   = reset || (state == HOLD);
  assign bus.check        = (fire && !reset) ? pick : '0;
  assign bus.armed        = !reset && (state == RUN);
  assign bus.done         = !reset && ((state == DONE) || (state == TIMEOUT));
  assign bus.timeout      = !reset && (state == TIMEOUT);
  assign bus.retire_count = retire_q;
  assign bus.cycle_count  = cycle_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb/tb_rvfi_check_sequencer.sv - randomized bench for rvfi_check_sequencer against a retirement-level model
module tb_rvfi_check_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  rvfi_check_sequencer_if #(.NRET(2), .CNT_W(16)) ifa ();
  rvfi_check_sequencer_if #(.NRET(4), .CNT_W(5))  ifb ();

  rvfi_check_sequencer #(
    .NRET(2), .RESET_CYCLES(2), .SKIP(3), .CHECK_DEPTH(20), .CNT_W(16)
  ) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (ifa)
  );

  rvfi_check_sequencer #(
    .NRET(4), .RESET_CYCLES(2), .SKIP(1), .CHECK_DEPTH(20), .CNT_W(5)
  ) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cur_cyc  = 0;
  int cur_id   = 0;

  int p_nret  [2] = '{2, 4};
  int p_rc    [2] = '{2, 2};
  int p_skip  [2] = '{3, 1};
  int p_depth [2] = '{20, 20};
  int p_max   [2] = '{65535, 31};

  logic [3:0] stim[$];

  logic [31:0] o_check, o_core, o_armed, o_done, o_to, o_rc, o_cc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, cur_id, cur_cyc, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic [3:0] v);
    if (id == 0) ifa.rvfi_valid = v[1:0];
    else         ifb.rvfi_valid = v;
  endtask

  task automatic sample(input int id);
    if (id == 0) begin
      o_check = 32'(ifa.check);     o_core = 32'(ifa.core_reset);
      o_armed = 32'(ifa.armed);     o_done = 32'(ifa.done);
      o_to    = 32'(ifa.timeout);   o_rc   = 32'(ifa.retire_count);
      o_cc    = 32'(ifa.cycle_count);
    end else begin
      o_check = 32'(ifb.check);     o_core = 32'(ifb.core_reset);
      o_armed = 32'(ifb.armed);     o_done = 32'(ifb.done);
      o_to    = 32'(ifb.timeout);   o_rc   = 32'(ifb.retire_count);
      o_cc    = 32'(ifb.cycle_count);
    end
  endtask

  function automatic logic [3:0] mask_of(input int id);
    return (id == 0) ? 4'b0011 : 4'b1111;
  endfunction

  task automatic set_reset(input int id, input logic r);
    if (id == 0) reset_a = r;
    else         reset_b = r;
  endtask

  // Two reset cycles with random valids; ends at the negedge of cycle 0.
  task automatic do_reset(input int id);
    cur_id  = id;
    cur_cyc = -2;
    set_reset(id, 1'b1);
    drive(id, 4'($urandom) & mask_of(id));
    @(posedge clock);
    @(negedge clock);
    cur_cyc = -1;
    drive(id, 4'($urandom) & mask_of(id));
    #2;
    sample(id);
    chk("rst_core_reset", o_core, 32'd1);
    chk("rst_check", o_check, 32'd0);
    chk("rst_armed", o_armed, 32'd0);
    chk("rst_done", o_done, 32'd0);
    chk("rst_timeout", o_to, 32'd0);
    chk("rst_retire_count", o_rc, 32'd0);
    chk("rst_cycle_count", o_cc, 32'd0);
    @(posedge clock);
    @(negedge clock);
    set_reset(id, 1'b0);
  endtask

  // Runs len cycles of stim[] against the model: retirements are counted in program
  // order (cycle, then LSB first) once the reset window is over.
  task automatic run_epoch(input int id, input int len);
    int t;
    int cnt;
    bit fin;
    bit tout;
    bit in_hold;
    int pos[$];
    logic [3:0]  v;
    logic [31:0] e_check;
    int e_cc;
    t    = 0;
    cnt  = 0;
    fin  = 1'b0;
    tout = 1'b0;
    for (int c = 0; c < len; c++) begin
      cur_cyc = c;
      v = (c < stim.size()) ? (stim[c] & mask_of(id)) : 4'b0000;
      drive(id, v);
      #2;
      sample(id);
      in_hold = (t < p_rc[id]);
      e_check = 32'd0;
      if (!in_hold && !fin) begin
        pos.delete();
        for (int b = 0; b < p_nret[id]; b++) if (v[b]) pos.push_back(b);
        if (cnt <= p_skip[id] && (p_skip[id] - cnt) < pos.size())
          e_check = 32'd1 << pos[p_skip[id] - cnt];
      end
      e_cc = (t > p_max[id]) ? p_max[id] : t;
      chk("check", o_check, e_check);
      chk("core_reset", o_core, 32'(in_hold));
      chk("armed", o_armed, 32'(!in_hold && !fin));
      chk("done", o_done, 32'(fin));
      chk("timeout", o_to, 32'(tout));
      chk("retire_count", o_rc, 32'(cnt));
      chk("cycle_count", o_cc, 32'(e_cc));
      if (!in_hold) begin
        cnt = cnt + $countones(v);
        if (cnt > p_max[id]) cnt = p_max[id];
        if (!fin) begin
          if (e_check != 0) fin = 1'b1;
          else if (t == p_depth[id] - 1) begin
            fin  = 1'b1;
            tout = 1'b1;
          end
        end
      end
      t++;
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic stim_zero(input int len);
    stim.delete();
    for (int i = 0; i < len; i++) stim.push_back(4'b0000);
  endtask

  task automatic stim_random(input int len, input int density);
    stim.delete();
    for (int i = 0; i < len; i++)
      stim.push_back(($urandom_range(0, 3) < density) ? 4'($urandom) : 4'b0000);
  endtask

  initial begin
    ifa.rvfi_valid = '0;
    ifb.rvfi_valid = '0;
    @(negedge clock);

    // Reset window and single-channel stream.
    stim_zero(25);
    stim[0] = 4'b0011; stim[1] = 4'b0011;
    for (int i = 2; i <= 5; i++) stim[i] = 4'b0001;
    do_reset(0);
    run_epoch(0, 25);

    // Dual retire: the 4th retirement is channel 1 of the second dual cycle.
    stim_zero(25);
    stim[3] = 4'b0011; stim[4] = 4'b0011;
    do_reset(0);
    run_epoch(0, 25);

    // Timeout, then late valids that must change nothing.
    stim_zero(28);
    for (int i = 20; i < 28; i++) stim[i] = 4'b0011;
    do_reset(0);
    run_epoch(0, 28);

    // Two retirements, reset in cycle 4, then a fresh epoch needing four more.
    stim_zero(4);
    stim[2] = 4'b0001; stim[3] = 4'b0001;
    do_reset(0);
    run_epoch(0, 4);
    stim_zero(12);
    for (int i = 2; i <= 7; i++) stim[i] = 4'b0001;
    do_reset(0);
    run_epoch(0, 12);

    for (int r = 0; r < 6; r++) begin
      stim_random(30, (r % 3) + 1);
      do_reset(0);
      run_epoch(0, 30);
    end

    // Non-contiguous pick on four channels, then saturation of both counters.
    stim_zero(40);
    stim[0] = 4'b1111;
    stim[2] = 4'b1010;
    for (int i = 5; i < 40; i++) stim[i] = 4'b1111;
    do_reset(1);
    run_epoch(1, 40);

    for (int r = 0; r < 4; r++) begin
      stim_random(36, (r % 3) + 1);
      do_reset(1);
      run_epoch(1, 36);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
